// File: rtl/timer0_engine_if.sv
// ----------------------------------------------------------------------------
// timer0_engine_if
// Purpose : SFR-side bundle between the Timer 0 counting engine and the
//           TL0/TH0 register blocks.
// Signals : i_tl0/i_th0            current register contents (into engine)
//           i_cpu_wr_tl0/_th0      CPU writes the register this cycle
//           o_tl0_wr/o_tl0_val     engine write-back strobe and value for TL0
//           o_th0_wr/o_th0_val     engine write-back strobe and value for TH0
// Modports: master = register side, slave = counting engine.
// Names are written from the engine's point of view (i_ = into engine).
// ----------------------------------------------------------------------------
interface timer0_engine_if;
    logic [7:0] i_tl0;
    logic [7:0] i_th0;
    logic       i_cpu_wr_tl0;
    logic       i_cpu_wr_th0;
    logic       o_tl0_wr;
    logic [7:0] o_tl0_val;
    logic       o_th0_wr;
    logic [7:0] o_th0_val;

    modport master (
        output i_tl0, i_th0, i_cpu_wr_tl0, i_cpu_wr_th0,
        input  o_tl0_wr, o_tl0_val, o_th0_wr, o_th0_val
    );

    modport slave (
        input  i_tl0, i_th0, i_cpu_wr_tl0, i_cpu_wr_th0,
        output o_tl0_wr, o_tl0_val, o_th0_wr, o_th0_val
    );
endinterface

// File: rtl/timer0_engine.sv
// ----------------------------------------------------------------------------
// timer0_engine
// Purpose : 8051 Timer 0 counting engine. Reads TL0/TH0, advances them per
//           TMOD mode on each machine-cycle tick or synchronized T0 falling
//           edge, and writes the result back through one-cycle strobes.
//           Also issues TF0/TF1 set pulses to the TCON logic.
// Ports   : i_clk, i_rst_n   clock, asynchronous active-low reset
//           sfr              timer0_engine_if.slave (TL0/TH0 read, write-back)
//           i_tmod[3:0]      {GATE, C/T, M1, M0}
//           i_tr0, i_tr1     run bits (TR1 only drives TH0 in mode 3)
//           i_int0, i_t0     asynchronous pins, synchronized here
//           o_tf0_set        one-cycle TF0 set pulse
//           o_tf1_set        one-cycle TF1 set pulse (mode 3 TH0 overflow)
// Parameter: CLK_DIV         clocks per machine cycle (>= 2)
// ----------------------------------------------------------------------------
module timer0_engine #(
    parameter int CLK_DIV = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    timer0_engine_if.slave        sfr,
    input  logic [3:0]            i_tmod,
    input  logic                  i_tr0,
    input  logic                  i_tr1,
    input  logic                  i_int0,
    input  logic                  i_t0,
    output logic                  o_tf0_set,
    output logic                  o_tf1_set
);

    localparam int            PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_13BIT = 2'd0,
        MODE_16BIT = 2'd1,
        MODE_AR8   = 2'd2,
        MODE_SPLIT = 2'd3
    } mode_e;

    // ---- prescaler and pin synchronizers ----
    logic [PW-1:0] r_presc;
    logic          r_t0_s1, r_t0_s2, r_t0_prev;
    logic          r_int0_s1, r_int0_s2;

    logic          w_tick;
    logic          w_t0_fall;
    logic          w_run0;
    logic          w_ev0;
    logic          w_ev_th;
    mode_e         w_mode;
    logic          w_gate;
    logic          w_ct;

    assign w_tick    = (r_presc == PRE_LAST);
    assign w_t0_fall = r_t0_prev & ~r_t0_s2;
    assign w_gate    = i_tmod[3];
    assign w_ct      = i_tmod[2];
    assign w_mode    = mode_e'(i_tmod[1:0]);
    assign w_run0    = i_tr0 & (~w_gate | r_int0_s2);
    assign w_ev0     = w_run0 & (w_ct ? w_t0_fall : w_tick);
    // TH0 as the split-mode timer counts machine cycles under TR1 only.
    assign w_ev_th   = w_tick & i_tr1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc   <= '0;
            r_t0_s1   <= 1'b1;
            r_t0_s2   <= 1'b1;
            r_t0_prev <= 1'b1;
            r_int0_s1 <= 1'b1;
            r_int0_s2 <= 1'b1;
        end else begin
            r_presc   <= w_tick ? '0 : r_presc + PW'(1);
            r_t0_s1   <= i_t0;
            r_t0_s2   <= r_t0_s1;
            r_t0_prev <= r_t0_s2;
            r_int0_s1 <= i_int0;
            r_int0_s2 <= r_int0_s1;
        end
    end

    // ---- stage p0: next-value computation from the live register contents ----
    logic [12:0] w_cnt13;
    logic [15:0] w_cnt16;
    logic [7:0]  w_tl0_inc;
    logic [7:0]  w_th0_inc;

    assign w_cnt13   = {sfr.i_th0, sfr.i_tl0[4:0]} + 13'd1;
    assign w_cnt16   = {sfr.i_th0, sfr.i_tl0} + 16'd1;
    assign w_tl0_inc = sfr.i_tl0 + 8'd1;
    assign w_th0_inc = sfr.i_th0 + 8'd1;

    logic       w_tl0_wr_p0;
    logic [7:0] w_tl0_val_p0;
    logic       w_th0_wr_p0;
    logic [7:0] w_th0_val_p0;
    logic       w_tf0_p0;
    logic       w_tf1_p0;

    always_comb begin
        w_tl0_wr_p0  = 1'b0;
        w_tl0_val_p0 = 8'h00;
        w_th0_wr_p0  = 1'b0;
        w_th0_val_p0 = 8'h00;
        w_tf0_p0     = 1'b0;
        w_tf1_p0     = 1'b0;
        unique case (w_mode)
            MODE_13BIT: begin
                if (w_ev0) begin
                    // TL0[7:5] are not part of the 13-bit count and pass through.
                    w_tl0_wr_p0  = 1'b1;
                    w_th0_wr_p0  = 1'b1;
                    w_tl0_val_p0 = {sfr.i_tl0[7:5], w_cnt13[4:0]};
                    w_th0_val_p0 = w_cnt13[12:5];
                    w_tf0_p0     = (w_cnt13 == 13'd0);
                end
            end
            MODE_16BIT: begin
                if (w_ev0) begin
                    w_tl0_wr_p0  = 1'b1;
                    w_th0_wr_p0  = 1'b1;
                    w_tl0_val_p0 = w_cnt16[7:0];
                    w_th0_val_p0 = w_cnt16[15:8];
                    w_tf0_p0     = (w_cnt16 == 16'd0);
                end
            end
            MODE_AR8: begin
                if (w_ev0) begin
                    w_tl0_wr_p0  = 1'b1;
                    w_tf0_p0     = (sfr.i_tl0 == 8'hFF);
                    w_tl0_val_p0 = w_tf0_p0 ? sfr.i_th0 : w_tl0_inc;
                end
            end
            MODE_SPLIT: begin
                if (w_ev0) begin
                    w_tl0_wr_p0  = 1'b1;
                    w_tl0_val_p0 = w_tl0_inc;
                    w_tf0_p0     = (sfr.i_tl0 == 8'hFF);
                end
                if (w_ev_th) begin
                    w_th0_wr_p0  = 1'b1;
                    w_th0_val_p0 = w_th0_inc;
                    w_tf1_p0     = (sfr.i_th0 == 8'hFF);
                end
            end
            default: ;
        endcase
    end

    // ---- stage p1: registered strobes, values and flag pulses ----
    logic       r_tl0_wr_p1;
    logic [7:0] r_tl0_val_p1;
    logic       r_th0_wr_p1;
    logic [7:0] r_th0_val_p1;
    logic       r_tf0_p1;
    logic       r_tf1_p1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tl0_wr_p1  <= 1'b0;
            r_tl0_val_p1 <= 8'h00;
            r_th0_wr_p1  <= 1'b0;
            r_th0_val_p1 <= 8'h00;
            r_tf0_p1     <= 1'b0;
            r_tf1_p1     <= 1'b0;
        end else begin
            r_tl0_wr_p1  <= w_tl0_wr_p0;
            r_tl0_val_p1 <= w_tl0_val_p0;
            r_th0_wr_p1  <= w_th0_wr_p0;
            r_th0_val_p1 <= w_th0_val_p0;
            r_tf0_p1     <= w_tf0_p0;
            r_tf1_p1     <= w_tf1_p0;
        end
    end

    // A CPU write in the strobe cycle wins; that increment is dropped but the
    // overflow flag pulse still goes out.
    assign sfr.o_tl0_wr  = r_tl0_wr_p1 & ~sfr.i_cpu_wr_tl0;
    assign sfr.o_th0_wr  = r_th0_wr_p1 & ~sfr.i_cpu_wr_th0;
    assign sfr.o_tl0_val = r_tl0_val_p1;
    assign sfr.o_th0_val = r_th0_val_p1;
    assign o_tf0_set     = r_tf0_p1;
    assign o_tf1_set     = r_tf1_p1;

endmodule

// File: tb/tb_timer0_engine.sv
module tb_timer0_engine;
    localparam int CLK_DIV = 12;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] tmod;
    logic       tr0, tr1, int0, t0;
    logic       tf0_set, tf1_set;

    timer0_engine_if bus ();

    timer0_engine #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .sfr       (bus),
        .i_tmod    (tmod),
        .i_tr0     (tr0),
        .i_tr1     (tr1),
        .i_int0    (int0),
        .i_t0      (t0),
        .o_tf0_set (tf0_set),
        .o_tf1_set (tf1_set)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state: cycle index since reset release, pin history
    int         cyc;
    bit         h1, h2, h3, ih1, ih2;
    logic       p_tlwr, p_thwr, p_tf0, p_tf1;
    logic [7:0] p_tlv, p_thv;

    // outputs sampled in the most recent step
    logic       s_tlwr, s_thwr, s_tf0, s_tf1;
    logic [7:0] s_tlv, s_thv;
    int         scyc;
    logic [7:0] cpu_tl0, cpu_th0;

    typedef struct {
        logic [3:0] tmod;
        logic       tr0, tr1, int0;
        logic [7:0] tl0, th0;
        logic       tlwr;
        logic [7:0] tlv;
        logic       thwr;
        logic [7:0] thv;
        logic       tf0, tf1;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reset_model();
        cyc = 0;
        h1 = 1; h2 = 1; h3 = 1; ih1 = 1; ih2 = 1;
        p_tlwr = 0; p_thwr = 0; p_tf0 = 0; p_tf1 = 0; p_tlv = 0; p_thv = 0;
    endtask

    // Behavioural rules: what should happen one cycle after this cycle's inputs.
    task automatic predict();
        int tl, th, n;
        bit tick, fall, run0, ev0, evh;
        tl   = int'(bus.i_tl0);
        th   = int'(bus.i_th0);
        tick = (cyc % CLK_DIV) == CLK_DIV - 1;
        fall = h3 && !h2;
        run0 = tr0 && (!tmod[3] || ih2);
        ev0  = run0 && (tmod[2] ? fall : tick);
        evh  = tick && tr1;
        p_tlwr = 0; p_thwr = 0; p_tf0 = 0; p_tf1 = 0; p_tlv = 0; p_thv = 0;
        case (tmod[1:0])
            2'd0: if (ev0) begin
                n = (th * 32 + tl % 32 + 1) % 8192;
                p_tlwr = 1; p_thwr = 1;
                p_tlv  = 8'((tl / 32) * 32 + n % 32);
                p_thv  = 8'(n / 32);
                p_tf0  = (n == 0);
            end
            2'd1: if (ev0) begin
                n = (th * 256 + tl + 1) % 65536;
                p_tlwr = 1; p_thwr = 1;
                p_tlv  = 8'(n % 256);
                p_thv  = 8'(n / 256);
                p_tf0  = (n == 0);
            end
            2'd2: if (ev0) begin
                p_tlwr = 1;
                if (tl == 255) begin p_tlv = 8'(th); p_tf0 = 1; end
                else p_tlv = 8'(tl + 1);
            end
            default: begin
                if (ev0) begin p_tlwr = 1; p_tlv = 8'((tl + 1) % 256); p_tf0 = (tl == 255); end
                if (evh) begin p_thwr = 1; p_thv = 8'((th + 1) % 256); p_tf1 = (th == 255); end
            end
        endcase
    endtask

    // One clock cycle: entered and left at posedge+1 with this cycle's inputs set.
    task automatic step();
        logic [19:0] got, want;
        @(negedge clk);
        s_tlwr = bus.o_tl0_wr; s_tlv = bus.o_tl0_val;
        s_thwr = bus.o_th0_wr; s_thv = bus.o_th0_val;
        s_tf0  = tf0_set;      s_tf1 = tf1_set;
        scyc   = cyc;
        got  = {s_tlwr, s_tlv, s_thwr, s_thv, s_tf0, s_tf1};
        want = {p_tlwr & ~bus.i_cpu_wr_tl0, p_tlv, p_thwr & ~bus.i_cpu_wr_th0, p_thv, p_tf0, p_tf1};
        chk("model", 32'(got), 32'(want));
        predict();
        @(posedge clk);
        #1;
        if (bus.i_cpu_wr_tl0) bus.i_tl0 = cpu_tl0; else if (s_tlwr) bus.i_tl0 = s_tlv;
        if (bus.i_cpu_wr_th0) bus.i_th0 = cpu_th0; else if (s_thwr) bus.i_th0 = s_thv;
        bus.i_cpu_wr_tl0 = 1'b0;
        bus.i_cpu_wr_th0 = 1'b0;
        h3 = h2; h2 = h1; h1 = t0;
        ih2 = ih1; ih1 = int0;
        cyc++;
    endtask

    task automatic wait_tick_cycle();
        repeat (3) step();
        for (int k = 0; k < 2 * CLK_DIV && (cyc % CLK_DIV) != CLK_DIV - 1; k++) step();
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 3))
            0: return 8'hFF;
            1: return 8'hFE;
            2: return 8'h1F;
            default: return 8'($urandom);
        endcase
    endfunction

    logic [31:0] allout;
    int first_c, second_c, nstb, fall_c, t0_cnt;

    initial begin
        vecs[0]  = '{4'h1, 1'b1, 1'b0, 1'b1, 8'hFE, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[1]  = '{4'h1, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{4'h2, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h9C, 1'b1, 8'h9C, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{4'h2, 1'b1, 1'b0, 1'b1, 8'h10, 8'h9C, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{4'h0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hE0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{4'h0, 1'b1, 1'b0, 1'b1, 8'h1F, 8'h05, 1'b1, 8'h00, 1'b1, 8'h06, 1'b0, 1'b0};
        vecs[6]  = '{4'h0, 1'b1, 1'b0, 1'b1, 8'h3F, 8'h12, 1'b1, 8'h20, 1'b1, 8'h13, 1'b0, 1'b0};
        vecs[7]  = '{4'h3, 1'b0, 1'b1, 1'b1, 8'h55, 8'hFF, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[8]  = '{4'h3, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h07, 1'b1, 8'h00, 1'b1, 8'h08, 1'b1, 1'b0};
        vecs[9]  = '{4'h1, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{4'h9, 1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{4'h9, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[12] = '{4'h3, 1'b1, 1'b0, 1'b1, 8'hFE, 8'hFF, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        tmod = 4'h0; tr0 = 1'b0; tr1 = 1'b0; int0 = 1'b1; t0 = 1'b1;
        bus.i_tl0 = 8'h00; bus.i_th0 = 8'h00;
        bus.i_cpu_wr_tl0 = 1'b0; bus.i_cpu_wr_th0 = 1'b0;
        cpu_tl0 = 8'h00; cpu_th0 = 8'h00;
        reset_model();

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tl0_wr", 32'(bus.o_tl0_wr), 32'd0);
        chk("rst_th0_wr", 32'(bus.o_th0_wr), 32'd0);
        allout = 32'({bus.o_tl0_val, bus.o_th0_val, tf0_set, tf1_set});
        chk("rst_vals", allout, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();

        // mode 1 from reset: FFFE -> FFFF at cycle CLK_DIV, -> 0000 with TF0 next tick
        tmod = 4'h1; tr0 = 1'b1;
        bus.i_tl0 = 8'hFE; bus.i_th0 = 8'hFF;
        first_c = -1; second_c = -1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (s_tlwr) begin
                if (first_c < 0) begin
                    first_c = scyc;
                    chk("m1_first", 32'({s_tlv, s_thv, s_thwr, s_tf0}), 32'({8'hFF, 8'hFF, 1'b1, 1'b0}));
                end else if (second_c < 0) begin
                    second_c = scyc;
                    chk("m1_wrap", 32'({s_tlv, s_thv, s_thwr, s_tf0}), 32'({8'h00, 8'h00, 1'b1, 1'b1}));
                end
            end
        end
        chk("m1_first_cyc", first_c, CLK_DIV);
        chk("m1_second_cyc", second_c, 2 * CLK_DIV);

        // reset pulse while a strobe is on the outputs, mid-prescale
        for (int k = 0; k < 20 && cyc < 3 * CLK_DIV; k++) step();
        chk("pre_rst_strobe", 32'(bus.o_th0_wr), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        allout = 32'({bus.o_tl0_wr, bus.o_th0_wr, bus.o_tl0_val, bus.o_th0_val, tf0_set, tf1_set});
        chk("rst_async_clear", allout, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
        first_c = -1;
        for (int i = 0; i < 20 && first_c < 0; i++) begin
            step();
            if (s_tlwr) begin
                first_c = scyc;
                chk("post_rst_val", 32'({s_tlv, s_thv}), 32'({8'h01, 8'h00}));
            end
        end
        chk("post_rst_first_cyc", first_c, CLK_DIV);

        // T0 counter: 5 falling edges, strobe 3 clocks after each
        tmod = 4'b0101;
        bus.i_tl0 = 8'h10; bus.i_th0 = 8'h00;
        nstb = 0;
        for (int k = 0; k < 5; k++) begin
            t0 = 1'b1;
            repeat (4) begin step(); if (s_tlwr) nstb++; end
            t0 = 1'b0; fall_c = cyc;
            repeat (4) begin
                step();
                if (s_tlwr) begin nstb++; chk("t0_latency", scyc - fall_c, 3); end
            end
        end
        chk("t0_count", nstb, 5);
        chk("t0_tl0", 32'(bus.i_tl0), 32'h15);

        // GATE=1 with INT0 low blocks the counter
        tmod = 4'b1101; int0 = 1'b0;
        nstb = 0;
        for (int k = 0; k < 5; k++) begin
            t0 = 1'b1; repeat (4) begin step(); if (s_tlwr) nstb++; end
            t0 = 1'b0; repeat (4) begin step(); if (s_tlwr) nstb++; end
        end
        chk("gate_blocked", nstb, 0);
        chk("gate_tl0", 32'(bus.i_tl0), 32'h15);
        t0 = 1'b1; int0 = 1'b1; tmod = 4'h0;

        // single-tick vector table
        for (int v = 0; v < 13; v++) begin
            tmod = vecs[v].tmod; tr0 = vecs[v].tr0; tr1 = vecs[v].tr1; int0 = vecs[v].int0;
            wait_tick_cycle();
            bus.i_tl0 = vecs[v].tl0; bus.i_th0 = vecs[v].th0;
            step();
            step();
            chk($sformatf("vec%0d", v),
                32'({s_tlwr, s_tlv, s_thwr, s_thv, s_tf0, s_tf1}),
                32'({vecs[v].tlwr, vecs[v].tlv, vecs[v].thwr, vecs[v].thv, vecs[v].tf0, vecs[v].tf1}));
        end
        int0 = 1'b1;

        // CPU write to TL0 in the strobe cycle: TL0 strobe suppressed, TH0 and TF0 still go
        tmod = 4'h3; tr0 = 1'b1; tr1 = 1'b1;
        wait_tick_cycle();
        bus.i_tl0 = 8'hFF; bus.i_th0 = 8'h80;
        step();
        bus.i_cpu_wr_tl0 = 1'b1; cpu_tl0 = 8'hAA;
        step();
        chk("coll_tl0_wr", 32'(s_tlwr), 32'd0);
        chk("coll_th0", 32'({s_thwr, s_thv}), 32'({1'b1, 8'h81}));
        chk("coll_tf0", 32'(s_tf0), 32'd1);
        chk("coll_regs", 32'({bus.i_tl0, bus.i_th0}), 32'({8'hAA, 8'h81}));

        // randomized run against the reference model
        tr0 = 1'b1; tr1 = 1'b1; t0_cnt = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) tmod = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) tr0 = ~tr0;
            if ($urandom_range(0, 49) == 0) tr1 = ~tr1;
            if ($urandom_range(0, 29) == 0) int0 = ~int0;
            t0_cnt = t0_cnt - 1;
            if (t0_cnt <= 0) begin t0 = ~t0; t0_cnt = int'($urandom_range(1, 4)); end
            if ($urandom_range(0, 15) == 0) begin bus.i_cpu_wr_tl0 = 1'b1; cpu_tl0 = pick(); end
            if ($urandom_range(0, 15) == 0) begin bus.i_cpu_wr_th0 = 1'b1; cpu_th0 = pick(); end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
